// File: rtl/egress_packet_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_PORTS store-and-forward egress
// buffers onto one Avalon-ST egress with a single registered output stage.
// A granted packet runs to its eop before the next arbitration decision.
module egress_packet_arbiter #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned EMPTY_WIDTH = 3,
    localparam int unsigned GW         = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             in_req,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS-1:0]             in_sop,
    input  logic [NUM_PORTS-1:0]             in_eop,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
    input  logic [NUM_PORTS-1:0]             in_error,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic                             o_valid,
    output logic                             o_sop,
    output logic                             o_eop,
    output logic                             o_error,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [EMPTY_WIDTH-1:0]           o_empty,
    input  logic                             o_ready,
    output logic [GW-1:0]                    o_grant,
    output logic                             o_busy,
    output logic                             o_proto_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic                   error;
        logic [DATA_WIDTH-1:0]  data;
        logic [EMPTY_WIDTH-1:0] empty;
    } beat_t;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_last_q, rr_last_d;
    logic          first_beat_q, first_beat_d;
    logic          valid_q, valid_d;
    beat_t         beat_q, beat_d;
    logic          proto_err_q, proto_err_d;

    beat_t         sel_beat;
    logic [GW-1:0] pick;
    logic          found;
    logic          out_free;
    logic          accept;
    int unsigned   idx;

    // Select the beat fields presented by the currently granted port
    always_comb begin
        sel_beat.sop   = in_sop[grant_q];
        sel_beat.eop   = in_eop[grant_q];
        sel_beat.error = in_error[grant_q];
        sel_beat.data  = in_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        sel_beat.empty = in_empty[32'(grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    // Round-robin scan starting just after the last port that completed a packet
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(rr_last_q) + i) % NUM_PORTS;
            if (!found && in_req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Output register is free when empty or draining this cycle
    assign out_free = !valid_q || o_ready;

    // Next-state, ready generation and output-stage load
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_last_d    = rr_last_q;
        first_beat_d = first_beat_q;
        valid_d      = valid_q;
        beat_d       = beat_q;
        proto_err_d  = proto_err_q;
        in_ready     = '0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d      = pick;
                    first_beat_d = 1'b1;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                in_ready[grant_q] = out_free;
                accept            = in_valid[grant_q] && out_free;
                if (accept) begin
                    first_beat_d = 1'b0;
                    // sop must appear on the first beat of a grant and nowhere else
                    if (first_beat_q != sel_beat.sop) begin
                        proto_err_d = 1'b1;
                    end
                    if (sel_beat.eop) begin
                        rr_last_d = grant_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            valid_d = 1'b1;
            beat_d  = sel_beat;
        end else if (o_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_last_q    <= GW'(NUM_PORTS - 1);
            first_beat_q <= 1'b0;
            valid_q      <= 1'b0;
            beat_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_last_q    <= rr_last_d;
            first_beat_q <= first_beat_d;
            valid_q      <= valid_d;
            beat_q       <= beat_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_sop       = beat_q.sop;
    assign o_eop       = beat_q.eop;
    assign o_error     = beat_q.error;
    assign o_data      = beat_q.data;
    assign o_empty     = beat_q.empty;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == ST_XFER);
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_egress_packet_arbiter.sv
// Directed bench for egress_packet_arbiter: per-port packet sources and an
// output capture queue advanced one clock at a time by tick().
module tb_egress_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     in_req, in_valid, in_sop, in_eop, in_error, in_ready;
    logic [NP*DW-1:0]  in_data;
    logic [NP*EW-1:0]  in_empty;
    logic              o_valid, o_sop, o_eop, o_error, o_ready, o_busy, o_proto_err;
    logic [DW-1:0]     o_data;
    logic [EW-1:0]     o_empty;
    logic [GW-1:0]     o_grant;

    egress_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
        .clk(clk), .reset(reset),
        .in_req(in_req), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
        .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_error(o_error),
        .o_data(o_data), .o_empty(o_empty), .o_ready(o_ready),
        .o_grant(o_grant), .o_busy(o_busy), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } obeat_t;

    // Source model: packets pending, length, beat index, packet count per port
    int      npk [NP];
    int      len [NP];
    int      bidx[NP];
    int      pcnt[NP];
    bit      nosop[NP];
    bit      xsop[NP];
    logic [NP-1:0] acc;
    logic    dn_ready;
    obeat_t  outq[$];
    int      checks = 0;
    int      failures = 0;

    function automatic logic [DW-1:0] mk(input int p, input int pc, input int b);
        return (DW'(p) << 48) | (DW'(pc) << 16) | DW'(b);
    endfunction

    // One clock: capture transfers, advance sources, then drive next beats
    task automatic tick();
        obeat_t ob;
        for (int p = 0; p < NP; p++) acc[p] = in_valid[p] && in_ready[p];
        if (o_valid && o_ready) begin
            ob.sop = o_sop; ob.eop = o_eop; ob.data = o_data;
            outq.push_back(ob);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                nosop[p] = 1'b0;
                bidx[p]++;
                if (bidx[p] == len[p]) begin
                    bidx[p] = 0;
                    pcnt[p]++;
                    npk[p]--;
                end
            end
        end
        o_ready  = dn_ready;
        in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0;
        for (int p = 0; p < NP; p++) in_req[p] = (npk[p] > 0);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (in_ready[p] && npk[p] > 0) begin
                in_valid[p] = 1'b1;
                in_sop[p]   = (bidx[p] == 0 && !nosop[p]) || xsop[p];
                in_eop[p]   = (bidx[p] == len[p] - 1);
                in_data[p*DW +: DW] = mk(p, pcnt[p], bidx[p]);
                in_empty[p*EW +: EW] = EW'(bidx[p]);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_req = '0; in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0;
        in_data = '0; in_empty = '0; o_ready = 1'b1; dn_ready = 1'b1; acc = '0;
        for (int p = 0; p < NP; p++) begin
            npk[p] = 0; len[p] = 1; bidx[p] = 0; pcnt[p] = 0; nosop[p] = 0; xsop[p] = 0;
        end
        outq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        o_ready = 1'b1; in_req = '1; in_valid = '1; in_sop = '1; in_eop = '0; in_error = '0;
        in_data = '1; in_empty = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        checks++; if (o_grant !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", o_grant); end
        checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", o_proto_err); end
        checks++; if ({o_sop, o_eop, o_error, o_data, o_empty} !== '0) begin
            failures++; $display("FAIL rst_beat got=%b%b%b %h %h exp=0", o_sop, o_eop, o_error, o_data, o_empty);
        end
        do_reset();
    endtask

    task automatic test_single_port();
        do_reset();
        npk[2] = 1; len[2] = 3;
        tick();
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL sp_idle_ready got=%b exp=0000", in_ready); end
        tick();
        checks++; if (o_grant !== 2'd2) begin failures++; $display("FAIL sp_grant got=%0d exp=2", o_grant); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL sp_busy got=%b exp=1", o_busy); end
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL sp_ready got=%b exp=0100", in_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL sp_lat got=%b exp=0", o_valid); end
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++;
            if ({o_valid, o_sop, o_eop, o_data, o_empty} !== {1'b1, b == 0, b == 2, mk(2, 0, b), EW'(b)}) begin
                failures++;
                $display("FAIL sp_beat%0d got=v%b s%b e%b %h %0d exp=v1 s%b e%b %h %0d", b,
                         o_valid, o_sop, o_eop, o_data, o_empty, b == 0, b == 2, mk(2, 0, b), b);
            end
        end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL sp_idle_after got=%b exp=0", o_busy); end
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL sp_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_round_robin();
        obeat_t e;
        int pk;
        do_reset();
        for (int p = 0; p < NP; p++) begin npk[p] = 2; len[p] = 2; end
        repeat (40) tick();
        checks++; if (outq.size() !== 16) begin failures++; $display("FAIL rr_count got=%0d exp=16", outq.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < outq.size()) begin
                pk = k / 2;
                e.sop = (k % 2 == 0); e.eop = (k % 2 == 1); e.data = mk(pk % 4, pk / 4, k % 2);
                checks++;
                if (outq[k] !== e) begin
                    failures++; $display("FAIL rr_beat%0d got=%h exp=%h", k, outq[k], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        obeat_t e;
        do_reset();
        npk[1] = 1; len[1] = 4;
        repeat (4) tick();
        checks++; if (o_data !== mk(1, 0, 1)) begin failures++; $display("FAIL bp_pre got=%h exp=%h", o_data, mk(1, 0, 1)); end
        dn_ready = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            checks++;
            if ({o_valid, o_data} !== {1'b1, mk(1, 0, 2)}) begin
                failures++; $display("FAIL bp_hold%0d got=v%b %h exp=v1 %h", s, o_valid, o_data, mk(1, 0, 2));
            end
            checks++;
            if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", s, in_ready); end
            tick();
        end
        dn_ready = 1'b1;
        repeat (6) tick();
        checks++; if (outq.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", outq.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < outq.size()) begin
                e.sop = (k == 0); e.eop = (k == 3); e.data = mk(1, 0, k);
                checks++;
                if (outq[k] !== e) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", k, outq[k], e); end
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        npk[1] = 1; len[1] = 1;
        npk[3] = 1; len[3] = 2;
        tick();
        tick();
        checks++; if (o_grant !== 2'd1) begin failures++; $display("FAIL sb_grant1 got=%0d exp=1", o_grant); end
        tick();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL sb_release got=%b exp=0", o_busy); end
        checks++;
        if ({o_valid, o_sop, o_eop, o_data} !== {3'b111, mk(1, 0, 0)}) begin
            failures++; $display("FAIL sb_beat got=v%b s%b e%b %h exp=v1 s1 e1 %h", o_valid, o_sop, o_eop, o_data, mk(1, 0, 0));
        end
        tick();
        checks++; if (o_grant !== 2'd3) begin failures++; $display("FAIL sb_grant3 got=%0d exp=3", o_grant); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL sb_busy3 got=%b exp=1", o_busy); end
        repeat (4) tick();
        checks++; if (outq.size() !== 3) begin failures++; $display("FAIL sb_count got=%0d exp=3", outq.size()); end
        if (outq.size() == 3) begin
            checks++;
            if (outq[2] !== {1'b0, 1'b1, mk(3, 0, 1)}) begin
                failures++; $display("FAIL sb_last got=%h exp=%h", outq[2], {1'b0, 1'b1, mk(3, 0, 1)});
            end
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        npk[0] = 1; len[0] = 2; nosop[0] = 1'b1;
        tick();
        tick();
        checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL pe_early got=%b exp=0", o_proto_err); end
        tick();
        checks++;
        if ({o_valid, o_sop, o_data} !== {1'b1, 1'b0, mk(0, 0, 0)}) begin
            failures++; $display("FAIL pe_fwd got=v%b s%b %h exp=v1 s0 %h", o_valid, o_sop, o_data, mk(0, 0, 0));
        end
        checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL pe_set got=%b exp=1", o_proto_err); end
        repeat (3) tick();
        npk[0] = 1;
        repeat (6) tick();
        checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL pe_sticky got=%b exp=1", o_proto_err); end
        checks++; if (outq.size() !== 4) begin failures++; $display("FAIL pe_count got=%0d exp=4", outq.size()); end
        do_reset();
        checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL pe_clear got=%b exp=0", o_proto_err); end
        // sop repeated on a non-first beat
        npk[2] = 1; len[2] = 2; xsop[2] = 1'b1;
        repeat (3) tick();
        checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL pe_sop1 got=%b exp=0", o_proto_err); end
        tick();
        checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL pe_sop2 got=%b exp=1", o_proto_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        npk[1] = 1; len[1] = 1;
        repeat (4) tick();
        npk[3] = 1; len[3] = 4;
        repeat (3) tick();
        checks++;
        if ({o_busy, o_grant, o_valid} !== {1'b1, 2'd3, 1'b1}) begin
            failures++; $display("FAIL rm_mid got=b%b g%0d v%b exp=b1 g3 v1", o_busy, o_grant, o_valid);
        end
        reset = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", o_valid); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rm_ready got=%b exp=0000", in_ready); end
        do_reset();
        npk[0] = 1; npk[2] = 1; npk[3] = 1;
        tick();
        tick();
        checks++; if (o_grant !== 2'd0) begin failures++; $display("FAIL rm_next_grant got=%0d exp=0", o_grant); end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_single_beat();
        test_proto_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
